sd_cmd_responder: RTL and testbench

//  Card-side end of the SD CMD line: receives 48-bit host commands, CRC7-checks them and

---
 rtl/sd_cmd_pkg.sv | 27 ++
 rtl/sd_crc7.sv | 28 ++
 rtl/sd_cmd_responder.sv | 175 +++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared SD CMD-line definitions: FSM states, frame layout and the CRC7 step.
// Also intended for reuse by a DAT-line responder.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX,
    ST_WAIT_RSP,
    ST_TX
  } sd_cmd_state_e;

  localparam int         SD_CMD_FRAME_LEN = 48;
  localparam logic [6:0] SD_CRC7_POLY     = 7'h09;
  localparam logic [6:0] SD_R3_CRC        = 7'h7F;

  // Bit positions within a frame, counted from the start bit (bit 0).
  localparam int SD_BIT_DIR = 1;
  localparam int SD_BIT_CRC = 40;
  localparam int SD_BIT_END = SD_CMD_FRAME_LEN - 1;

  function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one bit per clock; clr has priority over en.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = 7'h00;
    else if (en) crc_d = sd_crc7_step(crc_q, din);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) crc_q <= 7'h00;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line: receives and CRC-checks 48-bit host commands, then
// serialises the response offered by card logic inside the NCR window.
module sd_cmd_responder
  import sd_cmd_pkg::*;
#(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_crc_ok,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [5:0]  rsp_index,
  input  logic [31:0] rsp_arg,
  input  logic        rsp_no_crc,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int CW = $clog2(NCR_MAX + 1);

  if (NCR_MIN < 2 || NCR_MAX <= NCR_MIN) begin : g_bad_ncr
    $error("sd_cmd_responder: NCR_MIN must be >= 2 and NCR_MAX > NCR_MIN");
  end

  sd_cmd_state_e   state_q, state_d;
  logic [5:0]      bit_q, bit_d;
  logic [CW-1:0]   ncr_q, ncr_d;
  logic [44:0]     rx_sr_q, rx_sr_d;
  logic [5:0]      idx_q, idx_d;
  logic [31:0]     arg_q, arg_d;
  logic            crc_ok_q, crc_ok_d;
  logic            vld_q, vld_d;
  logic [39:0]     tx_sr_q, tx_sr_d;
  logic            no_crc_q, no_crc_d;

  logic [6:0]      crc;
  logic            crc_clr, crc_en, crc_din;
  logic            hs, rx_last, crc_match;
  logic [2:0]      crc_pos;

  // One CRC engine: checks incoming bits 0..39 in RX, generates outgoing CRC in TX.
  sd_crc7 u_crc7 (
    .clk  (clk),
    .rstn (rstn),
    .clr  (crc_clr),
    .en   (crc_en),
    .din  (crc_din),
    .crc  (crc)
  );

  assign crc_clr = (state_q == ST_IDLE) || (state_q == ST_WAIT_RSP);
  assign crc_en  = ((state_q == ST_RX) && (bit_q <= 6'(SD_BIT_CRC - 1))) || (state_q == ST_TX);
  assign crc_din = (state_q == ST_TX) ? cmd_out : cmd_in;

  // rx_sr holds frame bits 2..46; bit k sits at position 46-k once the end bit arrives.
  assign rx_last   = (state_q == ST_RX) && (bit_q == 6'(SD_BIT_END));
  assign crc_match = (rx_sr_q[6:0] == crc) && cmd_in;
  assign hs        = (state_q == ST_WAIT_RSP) && rsp_valid && rsp_ready;
  assign crc_pos   = 3'(6'(SD_BIT_END - 1) - bit_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    ncr_d    = ncr_q;
    rx_sr_d  = rx_sr_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    crc_ok_d = crc_ok_q;
    vld_d    = 1'b0;
    tx_sr_d  = tx_sr_q;
    no_crc_d = no_crc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!cmd_in) begin
          state_d = ST_RX;
          bit_d   = 6'd1;
          ncr_d   = '0;
        end
      end
      ST_RX: begin
        bit_d   = bit_q + 6'd1;
        rx_sr_d = {rx_sr_q[43:0], cmd_in};
        if (bit_q == 6'(SD_BIT_DIR) && !cmd_in) begin
          state_d = ST_IDLE;
        end else if (rx_last) begin
          vld_d    = 1'b1;
          idx_d    = rx_sr_q[44:39];
          arg_d    = rx_sr_q[38:7];
          crc_ok_d = crc_match;
          ncr_d    = CW'(1);
          state_d  = crc_match ? ST_WAIT_RSP : ST_IDLE;
        end
      end
      ST_WAIT_RSP: begin
        // Handshake beats both a new start bit and the window closing on the same edge.
        if (hs) begin
          state_d  = ST_TX;
          bit_d    = 6'd0;
          tx_sr_d  = {2'b00, rsp_index, rsp_arg};
          no_crc_d = rsp_no_crc;
        end else if (!cmd_in) begin
          state_d = ST_RX;
          bit_d   = 6'd1;
          ncr_d   = '0;
        end else if (ncr_q == CW'(NCR_MAX)) begin
          state_d = ST_IDLE;
        end else begin
          ncr_d = ncr_q + CW'(1);
        end
      end
      ST_TX: begin
        bit_d   = bit_q + 6'd1;
        tx_sr_d = {tx_sr_q[38:0], 1'b0};
        if (bit_q == 6'(SD_BIT_END)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_q    <= '0;
      ncr_q    <= '0;
      rx_sr_q  <= '0;
      idx_q    <= '0;
      arg_q    <= '0;
      crc_ok_q <= 1'b0;
      vld_q    <= 1'b0;
      tx_sr_q  <= '0;
      no_crc_q <= 1'b0;
    end else begin
      bit_q    <= bit_d;
      ncr_q    <= ncr_d;
      rx_sr_q  <= rx_sr_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      crc_ok_q <= crc_ok_d;
      vld_q    <= vld_d;
      tx_sr_q  <= tx_sr_d;
      no_crc_q <= no_crc_d;
    end
  end

  always_comb begin
    cmd_oe      = (state_q == ST_TX);
    cmd_out     = 1'b1;
    rsp_ready   = (state_q == ST_WAIT_RSP) && (ncr_q >= CW'(NCR_MIN)) && (ncr_q < CW'(NCR_MAX));
    rsp_timeout = (state_q == ST_WAIT_RSP) && (ncr_q == CW'(NCR_MAX)) && cmd_in;
    busy        = (state_q != ST_IDLE);
    if (state_q == ST_TX) begin
      // CRC bits come straight off the engine's MSB; feeding them back just shifts it.
      if (bit_q < 6'(SD_BIT_CRC))      cmd_out = tx_sr_q[39];
      else if (bit_q < 6'(SD_BIT_END)) cmd_out = no_crc_q ? SD_R3_CRC[crc_pos] : crc[6];
    end
  end

  assign cmd_valid  = vld_q;
  assign cmd_index  = idx_q;
  assign cmd_arg    = arg_q;
  assign cmd_crc_ok = crc_ok_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: frames driven on negedge, outputs checked 1ns later.
module tb_sd_cmd_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_in;
  logic        cmd_out, cmd_oe, cmd_valid, cmd_crc_ok;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        rsp_valid, rsp_ready, rsp_no_crc, rsp_timeout, busy;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;

  int n_tests = 0;
  int n_fail  = 0;
  int to_cnt  = 0;

  sd_cmd_responder #(.NCR_MIN(2), .NCR_MAX(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_in      (cmd_in),
    .cmd_out     (cmd_out),
    .cmd_oe      (cmd_oe),
    .cmd_valid   (cmd_valid),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .cmd_crc_ok  (cmd_crc_ok),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_index   (rsp_index),
    .rsp_arg     (rsp_arg),
    .rsp_no_crc  (rsp_no_crc),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #2;
    if (rsp_timeout === 1'b1) to_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [47:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      cmd_in = f[47 - i];
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    send_bits(f, 48);
  endtask

  // Captures 48 line bits starting at the next cycle, then checks the line is released.
  task automatic capture(input string tag, output logic [47:0] r);
    int oe_bad;
    oe_bad = 0;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      step();
      r = {r[46:0], cmd_out};
      if (cmd_oe !== 1'b1) oe_bad++;
    end
    chk({tag, "_oe_during"}, oe_bad, 0);
    step();
    chk({tag, "_oe_after"}, cmd_oe, 1'b0);
    chk({tag, "_line_after"}, cmd_out, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_out"}, cmd_out, 1'b1);
    chk({tag, "_cmd_oe"}, cmd_oe, 1'b0);
    chk({tag, "_valid"}, cmd_valid, 1'b0);
    chk({tag, "_index"}, cmd_index, 6'd0);
    chk({tag, "_arg"}, cmd_arg, 32'd0);
    chk({tag, "_crc_ok"}, cmd_crc_ok, 1'b0);
    chk({tag, "_ready"}, rsp_ready, 1'b0);
    chk({tag, "_timeout"}, rsp_timeout, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [47:0] r;
    logic [47:0] f41;
    logic [39:0] r7_hdr;
    int nready, first_to, ntmo, to_before, nvld;

    rstn = 1'b0; cmd_in = 1'b1; rsp_valid = 1'b0;
    rsp_index = '0; rsp_arg = '0; rsp_no_crc = 1'b0;
    step(); step();
    chk_reset_outputs("rst");
    @(negedge clk); rstn = 1'b1;
    step(); step();

    // CMD0
    send_frame(48'h40_0000_0000_95);
    step();
    chk("cmd0_valid", cmd_valid, 1'b1);
    chk("cmd0_index", cmd_index, 6'd0);
    chk("cmd0_arg", cmd_arg, 32'd0);
    chk("cmd0_crc_ok", cmd_crc_ok, 1'b1);
    step();
    chk("cmd0_valid_pulse", cmd_valid, 1'b0);
    for (int k = 0; k < 66; k++) step();
    chk("cmd0_idle", busy, 1'b0);

    // CMD8 with R7 offered before the command ends
    rsp_valid = 1'b1; rsp_index = 6'd8; rsp_arg = 32'h0000_01AA; rsp_no_crc = 1'b0;
    to_before = to_cnt;
    send_frame(48'h48_0000_01AA_87);
    step();
    chk("cmd8_valid", cmd_valid, 1'b1);
    chk("cmd8_index", cmd_index, 6'd8);
    chk("cmd8_arg", cmd_arg, 32'h1AA);
    chk("cmd8_crc_ok", cmd_crc_ok, 1'b1);
    chk("cmd8_ready_e1", rsp_ready, 1'b0);
    step();
    chk("cmd8_ready_e2", rsp_ready, 1'b1);
    capture("r7", r);
    r7_hdr = {2'b00, 6'd8, 32'h0000_01AA};
    chk("r7_frame", r, {r7_hdr, crc7(r7_hdr), 1'b1});
    rsp_valid = 1'b0;
    chk("r7_no_timeout", to_cnt, to_before);

    // CMD8 with the last CRC bit flipped
    rsp_valid = 1'b1;
    send_frame(48'h48_0000_01AA_85);
    step();
    chk("bad_crc_valid", cmd_valid, 1'b1);
    chk("bad_crc_ok", cmd_crc_ok, 1'b0);
    chk("bad_crc_busy", busy, 1'b0);
    nready = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rsp_ready) nready++;
    end
    chk("bad_crc_no_ready", nready, 0);
    rsp_valid = 1'b0;

    // No response: window opens at E+2, closes after E+63, timeout pulse at E+64
    to_before = to_cnt;
    send_frame(48'h40_0000_0000_95);
    nready = 0; first_to = 0; ntmo = 0;
    for (int k = 1; k <= 66; k++) begin
      step();
      if (rsp_ready) nready++;
      if (rsp_timeout) begin
        ntmo++;
        if (first_to == 0) first_to = k;
      end
    end
    chk("tmo_ready_cycles", nready, 62);
    chk("tmo_first_cycle", first_to, 64);
    chk("tmo_pulses", ntmo, 1);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_count", to_cnt, to_before + 1);

    // Next CMD0 starts 8 clocks after the previous end bit, inside the window
    to_before = to_cnt;
    send_frame(48'h40_0000_0000_95);
    for (int k = 0; k < 7; k++) step();
    send_frame(mk_frame(6'd0, 32'd0));
    step();
    chk("rewin_valid", cmd_valid, 1'b1);
    chk("rewin_index", cmd_index, 6'd0);
    chk("rewin_crc_ok", cmd_crc_ok, 1'b1);
    chk("rewin_no_timeout", to_cnt, to_before);
    for (int k = 0; k < 70; k++) step();
    chk("rewin_late_timeout", to_cnt, to_before + 1);

    // ACMD41, R3 handshaken on the last cycle of the window
    f41 = mk_frame(6'd41, 32'h40FF_8000);
    rsp_index = 6'h3F; rsp_arg = 32'h80FF_8000; rsp_no_crc = 1'b1;
    to_before = to_cnt;
    send_frame(f41);
    step();
    chk("acmd41_index", cmd_index, 6'd41);
    chk("acmd41_arg", cmd_arg, 32'h40FF_8000);
    chk("acmd41_crc_ok", cmd_crc_ok, 1'b1);
    for (int k = 2; k <= 62; k++) step();
    @(negedge clk);
    rsp_valid = 1'b1;
    #1;
    chk("r3_ready_last", rsp_ready, 1'b1);
    capture("r3", r);
    rsp_valid = 1'b0;
    rsp_no_crc = 1'b0;
    chk("r3_frame", r, 48'h3F_80FF_8000_FF);
    chk("r3_no_timeout", to_cnt, to_before);

    // Direction bit 0: abort, nothing reported
    send_bits(48'h00_0000_0000_01, 2);
    @(negedge clk); cmd_in = 1'b1;
    nvld = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (cmd_valid) nvld++;
    end
    chk("dir0_no_valid", nvld, 0);
    chk("dir0_idle", busy, 1'b0);

    // Reset during RX bit 20
    send_bits(48'h48_0000_01AA_87, 21);
    @(negedge clk);
    #1;
    chk("rx_mid_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("rst_rx");
    @(negedge clk); cmd_in = 1'b1;
    @(negedge clk); rstn = 1'b1;
    step(); step();

    // CMD8 after release, then reset during TX bit 30
    rsp_valid = 1'b1; rsp_index = 6'd8; rsp_arg = 32'h0000_01AA;
    send_frame(48'h48_0000_01AA_87);
    step();
    chk("post_rx_valid", cmd_valid, 1'b1);
    chk("post_rx_index", cmd_index, 6'd8);
    chk("post_rx_arg", cmd_arg, 32'h1AA);
    chk("post_rx_crc_ok", cmd_crc_ok, 1'b1);
    for (int k = 2; k <= 33; k++) step();
    chk("tx_mid_oe", cmd_oe, 1'b1);
    chk("tx_mid_bit30", cmd_out, r7_hdr[9]);
    rsp_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("rst_tx");
    @(negedge clk); rstn = 1'b1;
    step(); step();
    send_frame(48'h40_0000_0000_95);
    step();
    chk("post_tx_valid", cmd_valid, 1'b1);
    chk("post_tx_index", cmd_index, 6'd0);
    chk("post_tx_arg", cmd_arg, 32'd0);
    chk("post_tx_crc_ok", cmd_crc_ok, 1'b1);
    for (int k = 0; k < 70; k++) step();
    chk("final_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
